// File: rtl/test_sel_sequencer_pkg.sv
// rtl/test_sel_sequencer_pkg.sv - shared types, code constants and helpers for the selection sequencer
package test_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GUARD  = 2'd1,
    SETTLE = 2'd2,
    DWELL  = 2'd3
  } state_t;

  localparam logic [3:0] SEL_OFF   = 4'd0;
  localparam logic [3:0] SEL_FIRST = 4'd1;
  localparam logic [3:0] SEL_LAST  = 4'd15;

  // Moving between two different nonzero codes must pass through all-off first.
  function automatic logic needs_guard(input logic [3:0] cur, input logic [3:0] tgt);
    return (cur != SEL_OFF) && (tgt != SEL_OFF) && (cur != tgt);
  endfunction

  // Width of the shared interval counter; it only ever holds N-1 of the longest interval.
  function automatic int cnt_width(input int g, input int s, input int d);
    int m;
    m = g;
    if (s > m) m = s;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/test_sel_sequencer_if.sv
// rtl/test_sel_sequencer_if.sv - host-side command/scan bus and decoder outputs of the sequencer
interface test_sel_sequencer_if;
  logic       cmd_valid;
  logic [3:0] cmd_sel;
  logic       cmd_ready;
  logic       scan_start;
  logic       scan_abort;
  logic [3:0] sel;
  logic       settled;
  logic       scan_active;
  logic       done;

  modport master (
    output cmd_valid, cmd_sel, scan_start, scan_abort,
    input  cmd_ready, sel, settled, scan_active, done
  );

  modport slave (
    input  cmd_valid, cmd_sel, scan_start, scan_abort,
    output cmd_ready, sel, settled, scan_active, done
  );
endinterface

// File: rtl/test_sel_sequencer_timer.sv
// rtl/test_sel_sequencer_timer.sv - loadable down-counter shared by guard, settle and dwell intervals
module sel_interval_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Load on interval entry, then count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/test_sel_sequencer.sv
// rtl/test_sel_sequencer.sv - break-before-make sequencer for the block-enable decoder select code
module test_sel_sequencer
  import test_sel_pkg::*;
#(
  parameter int GUARD_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 256,
  parameter int DWELL_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  test_sel_sequencer_if.slave  bus
);

  localparam int CW = cnt_width(GUARD_CYCLES, SETTLE_CYCLES, DWELL_CYCLES);

  state_t        state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    tgt_q, tgt_d;
  logic          scan_q, scan_d;
  logic          done_q, done_d;
  logic          hold_q, hold_d;
  logic          ld;
  logic [CW-1:0] ld_val;
  logic          zero;
  logic          ready;
  logic          start;
  logic [3:0]    start_tgt;

  // hold_q marks the done cycle of a same-code command, during which no new command is taken.
  assign ready = (state_q == IDLE) && !scan_q && !hold_q;

  sel_interval_timer #(.WIDTH(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .zero     (zero)
  );

  // State, code and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_OFF;
      tgt_q   <= SEL_OFF;
      scan_q  <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      scan_q  <= scan_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: pick a target, route it via GUARD when needed, and let abort override all.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    tgt_d     = tgt_q;
    scan_d    = scan_q;
    done_d    = 1'b0;
    hold_d    = 1'b0;
    ld        = 1'b0;
    ld_val    = '0;
    start     = 1'b0;
    start_tgt = SEL_OFF;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && ready) begin
          if (bus.cmd_sel == sel_q) begin
            done_d = 1'b1;
            hold_d = 1'b1;
          end else begin
            start     = 1'b1;
            start_tgt = bus.cmd_sel;
          end
        end else if (bus.scan_start && ready) begin
          scan_d    = 1'b1;
          start     = 1'b1;
          start_tgt = SEL_FIRST;
        end
      end
      GUARD: begin
        if (zero) begin
          sel_d   = tgt_q;
          state_d = SETTLE;
          ld      = 1'b1;
          ld_val  = CW'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (zero) begin
          if (scan_q && (sel_q != SEL_OFF)) begin
            state_d = DWELL;
            ld      = 1'b1;
            ld_val  = CW'(DWELL_CYCLES - 1);
          end else begin
            state_d = IDLE;
            scan_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DWELL: begin
        if (zero) begin
          start     = 1'b1;
          start_tgt = (sel_q == SEL_LAST) ? SEL_OFF : sel_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      tgt_d = start_tgt;
      ld    = 1'b1;
      if (needs_guard(sel_q, start_tgt)) begin
        sel_d   = SEL_OFF;
        state_d = GUARD;
        ld_val  = CW'(GUARD_CYCLES - 1);
      end else begin
        sel_d   = start_tgt;
        state_d = SETTLE;
        ld_val  = CW'(SETTLE_CYCLES - 1);
      end
    end

    if (scan_q && bus.scan_abort) begin
      sel_d   = SEL_OFF;
      tgt_d   = SEL_OFF;
      state_d = SETTLE;
      scan_d  = 1'b1;
      done_d  = 1'b0;
      ld      = 1'b1;
      ld_val  = CW'(SETTLE_CYCLES - 1);
    end
  end

  assign bus.cmd_ready   = ready;
  assign bus.sel         = sel_q;
  assign bus.settled     = (state_q == IDLE) || (state_q == DWELL);
  assign bus.scan_active = scan_q;
  assign bus.done        = done_q;

endmodule
